// File: rtl/frame_scheduler.sv
// Frame-level round-robin scheduler for one crossbar TX port.
// Grants one VC per frame, holds it to EOF (or stall timeout), then idles P_IFG cycles.
module frame_scheduler #(
    parameter int P_WIDTH   = 3,
    parameter int P_IFG     = 12,
    parameter int P_TIMEOUT = 256
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [P_WIDTH-1:0] request_i,
    input  logic [P_WIDTH-1:0] eof_i,
    input  logic               enable_i,
    output logic [P_WIDTH-1:0] grant_o,
    output logic               busy_o,
    output logic               stall_o,
    output logic               abort_o,
    output logic [15:0]        frame_count_o
);
    localparam int IDX_W      = $clog2(P_WIDTH);
    localparam int GAP_W      = $clog2(P_IFG + 1);
    localparam int STALL_W    = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
    localparam int STALL_LAST = (P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   winner_q;
    logic [IDX_W-1:0]   last_q;
    logic [GAP_W-1:0]   gap_q;
    logic [STALL_W-1:0] stall_q;
    logic               busy_q;
    logic               abort_q;
    logic [15:0]        frame_cnt_q;

    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic [P_WIDTH-1:0] win_oh;
    logic               win_req;
    logic               win_eof;
    logic               start_ok;

    // Walk candidates farthest-first so the nearest requester after last_q wins.
    always_comb begin
        sel_idx = last_q;
        cand    = last_q;
        for (int k = P_WIDTH; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % P_WIDTH);
            if (request_i[cand]) sel_idx = cand;
        end
    end

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < P_WIDTH; i++) begin
            win_oh[i] = (winner_q == IDX_W'(i));
        end
    end

    assign win_req  = |(win_oh & request_i);
    assign win_eof  = |(win_oh & request_i & eof_i);
    assign start_ok = enable_i & (|request_i);

    assign grant_o       = (state_q == GRANT) ? (win_oh & request_i) : '0;
    assign stall_o       = (state_q == GRANT) & ~win_req;
    assign busy_o        = busy_q;
    assign abort_o       = abort_q;
    assign frame_count_o = frame_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            last_q      <= IDX_W'(P_WIDTH - 1);
            gap_q       <= '0;
            stall_q     <= '0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q  <= GRANT;
                        winner_q <= sel_idx;
                        last_q   <= sel_idx;
                        stall_q  <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (win_req) begin
                        stall_q <= '0;
                        if (win_eof) begin
                            state_q     <= GAP;
                            gap_q       <= GAP_W'(P_IFG);
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                    end else if (P_TIMEOUT > 0) begin
                        // This stall cycle is the P_TIMEOUT-th in a row: give up on the frame.
                        if (stall_q == STALL_W'(STALL_LAST)) begin
                            state_q <= GAP;
                            gap_q   <= GAP_W'(P_IFG);
                            stall_q <= '0;
                            abort_q <= 1'b1;
                        end else begin
                            stall_q <= stall_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    gap_q <= gap_q - 1'b1;
                    if (gap_q == GAP_W'(1)) begin
                        if (start_ok) begin
                            state_q  <= GRANT;
                            winner_q <= sel_idx;
                            last_q   <= sel_idx;
                            stall_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
